noc_packet_injector: RTL and testbench

Per-node network-interface transmitter that converts core-side packet requests into wormhole flit streams for the local (port 4) input of a mesh router. It accepts a destination and a body length, emits a head flit, then streams body flits from a payload handshake, tagging the last one as tail. It obeys the router's on/off backpressure (`router_out_full`). One instance sits beside each router, driving one slice of `local_in_flit_flat`/`local_wr_en_flat` and observing the matching `router_out_full_flat` bit.

---
 rtl/noc_packet_injector.sv | 154 +++++++++++++++
 tb/tb_noc_packet_injector.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_packet_injector.sv
// noc_packet_injector: turns core packet descriptors plus a payload stream into
// wormhole flits for the router local input, honouring on/off backpressure.
// Optional build macro: NOC_INJECTOR_STATS_EN adds saturating stat counters.
module noc_packet_injector #(
   parameter  int LINK_WIDTH = 8,
   parameter  int MESH_DIM   = 4,
   parameter  int MAX_LEN    = 15,
   localparam int ID_W       = $clog2(MESH_DIM*MESH_DIM),
   localparam int LEN_W      = $clog2(MAX_LEN+1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  pkt_valid,
   output logic                  pkt_ready,
   input  logic [ID_W-1:0]       pkt_dest,
   input  logic [LEN_W-1:0]      pkt_len,
   input  logic                  data_valid,
   output logic                  data_ready,
   input  logic [LINK_WIDTH-3:0] data,
   output logic [LINK_WIDTH-1:0] local_in_flit,
   output logic                  local_wr_en,
   input  logic                  router_out_full,
   output logic                  busy
`ifdef NOC_INJECTOR_STATS_EN
   ,
   output logic [15:0]           stat_pkts,
   output logic [15:0]           stat_flits,
   output logic [15:0]           stat_stalls
`endif
);

   localparam int BODY_W = LINK_WIDTH-2;

   localparam logic [1:0] TYPE_BODY   = 2'b00;
   localparam logic [1:0] TYPE_HEAD   = 2'b01;
   localparam logic [1:0] TYPE_TAIL   = 2'b10;
   localparam logic [1:0] TYPE_SINGLE = 2'b11;

   typedef enum logic [1:0] {IDLE, HEAD, BODY} state_t;

   state_t             state;
   logic [ID_W-1:0]    dest_q;
   logic [LEN_W-1:0]   len_q;
   logic [LEN_W-1:0]   remaining;
   logic               pkt_ready_q;
   logic               busy_q;
   logic [BODY_W-1:0]  head_body;
   logic               len_zero;
   logic               last_body;

   assign len_zero  = (len_q == '0);
   assign last_body = (remaining == LEN_W'(1));

   assign pkt_ready = pkt_ready_q;
   assign busy      = busy_q;

   // Flit mux and send strobes; the send decision must see full/data_valid this cycle.
   always_comb begin
      head_body                = '0;
      head_body[ID_W-1:0]      = dest_q;
      local_wr_en              = 1'b0;
      data_ready               = 1'b0;
      local_in_flit            = '0;
      case (state)
         HEAD: begin
            local_wr_en   = !router_out_full;
            local_in_flit = {(len_zero ? TYPE_SINGLE : TYPE_HEAD), head_body};
         end
         BODY: begin
            local_wr_en   = data_valid && !router_out_full;
            data_ready    = data_valid && !router_out_full;
            local_in_flit = {(last_body ? TYPE_TAIL : TYPE_BODY), data};
         end
         default: ;
      endcase
   end

   // Packet FSM; pkt_ready/busy are registered alongside the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         dest_q      <= '0;
         len_q       <= '0;
         remaining   <= '0;
         pkt_ready_q <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (pkt_valid) begin
                  dest_q      <= pkt_dest;
                  len_q       <= pkt_len;
                  state       <= HEAD;
                  pkt_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
               end
            end
            HEAD: begin
               if (local_wr_en) begin
                  if (len_zero) begin
                     state       <= IDLE;
                     pkt_ready_q <= 1'b1;
                     busy_q      <= 1'b0;
                  end else begin
                     remaining <= len_q;
                     state     <= BODY;
                  end
               end
            end
            BODY: begin
               if (local_wr_en) begin
                  remaining <= remaining - LEN_W'(1);
                  if (last_body) begin
                     state       <= IDLE;
                     pkt_ready_q <= 1'b1;
                     busy_q      <= 1'b0;
                  end
               end
            end
            default: begin
               state       <= IDLE;
               pkt_ready_q <= 1'b1;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

`ifdef NOC_INJECTOR_STATS_EN
   logic sent_last;
   logic stalled;

   assign sent_last = local_wr_en &&
                      (((state == HEAD) && len_zero) || ((state == BODY) && last_body));
   assign stalled   = (state != IDLE) && router_out_full;

   // Saturating statistics counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_pkts   <= '0;
         stat_flits  <= '0;
         stat_stalls <= '0;
      end else begin
         if (sent_last && (stat_pkts != 16'hFFFF))
            stat_pkts <= stat_pkts + 16'd1;
         if (local_wr_en && (stat_flits != 16'hFFFF))
            stat_flits <= stat_flits + 16'd1;
         if (stalled && (stat_stalls != 16'hFFFF))
            stat_stalls <= stat_stalls + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_noc_packet_injector.sv
// Bench for noc_packet_injector: directed vector table, hand sequences for
// reset-mid-packet and max length, then random traffic against a flit-queue model.
module tb_noc_packet_injector;

   logic       clk = 1'b0;
   logic       rst;
   logic       pkt_valid;
   logic       pkt_ready;
   logic [3:0] pkt_dest;
   logic [3:0] pkt_len;
   logic       data_valid;
   logic       data_ready;
   logic [5:0] data;
   logic [7:0] local_in_flit;
   logic       local_wr_en;
   logic       router_out_full;
   logic       busy;
`ifdef NOC_INJECTOR_STATS_EN
   logic [15:0] stat_pkts, stat_flits, stat_stalls;
`endif

   noc_packet_injector dut (
      .clk(clk), .rst(rst),
      .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
      .pkt_dest(pkt_dest), .pkt_len(pkt_len),
      .data_valid(data_valid), .data_ready(data_ready), .data(data),
      .local_in_flit(local_in_flit), .local_wr_en(local_wr_en),
      .router_out_full(router_out_full), .busy(busy)
`ifdef NOC_INJECTOR_STATS_EN
      , .stat_pkts(stat_pkts), .stat_flits(stat_flits), .stat_stalls(stat_stalls)
`endif
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs after the falling edge, then let outputs settle.
   task automatic cyc_in(input logic r, input logic pv, input logic [3:0] d, input logic [3:0] l,
                         input logic dv, input logic [5:0] dat, input logic f);
      @(negedge clk);
      rst = r; pkt_valid = pv; pkt_dest = d; pkt_len = l;
      data_valid = dv; data = dat; router_out_full = f;
      #2;
   endtask

   typedef struct packed {
      logic       pv;
      logic [3:0] d;
      logic [3:0] l;
      logic       dv;
      logic [5:0] dat;
      logic       f;
      logic       e_pr;
      logic       e_dr;
      logic       e_wr;
      logic [7:0] e_flit;
      logic       e_busy;
   } vec_t;

   function automatic vec_t mk(input logic pv, input logic [3:0] d, input logic [3:0] l,
                               input logic dv, input logic [5:0] dat, input logic f,
                               input logic pr, input logic dr, input logic wr,
                               input logic [7:0] fl, input logic bz);
      vec_t v;
      v.pv = pv; v.d = d; v.l = l; v.dv = dv; v.dat = dat; v.f = f;
      v.e_pr = pr; v.e_dr = dr; v.e_wr = wr; v.e_flit = fl; v.e_busy = bz;
      return v;
   endfunction

   // Expected-flit queue: what the router must receive for all accepted packets.
   typedef struct packed {
      logic [1:0] typ;
      logic       use_data;
      logic [5:0] body;
   } exp_t;
   exp_t q[$];

   task automatic model_cycle();
      exp_t e;
      logic exp_wr;
      logic accept;
      if (q.size() == 0) begin
         chk("idle_pkt_ready", pkt_ready, 1);
         chk("idle_busy", busy, 0);
         chk("idle_wr_en", local_wr_en, 0);
         chk("idle_data_ready", data_ready, 0);
         chk("idle_flit", local_in_flit, 0);
         accept = pkt_valid;
      end else begin
         e = q[0];
         exp_wr = !router_out_full && (!e.use_data || data_valid);
         chk("pkt_pkt_ready", pkt_ready, 0);
         chk("pkt_busy", busy, 1);
         chk("pkt_wr_en", local_wr_en, exp_wr);
         chk("pkt_data_ready", data_ready, e.use_data && exp_wr);
         chk("pkt_flit", local_in_flit, {e.typ, (e.use_data ? data : e.body)});
         if (exp_wr) void'(q.pop_front());
         accept = 1'b0;
      end
      if (accept) begin
         e.typ = (pkt_len == 0) ? 2'b11 : 2'b01;
         e.use_data = 1'b0;
         e.body = {2'b00, pkt_dest};
         q.push_back(e);
         for (int i = 1; i <= int'(pkt_len); i++) begin
            e.typ = (i == int'(pkt_len)) ? 2'b10 : 2'b00;
            e.use_data = 1'b1;
            e.body = '0;
            q.push_back(e);
         end
      end
      if (rst) q.delete();
   endtask

   vec_t tbl[25];

   initial begin
      int nfl, ntail;
      logic [7:0] first_flit, last_flit;
`ifdef NOC_INJECTOR_STATS_EN
      logic [15:0] pk0;
`endif

      //             pv d   l  dv dat    f   pr dr wr flit   bz
      tbl[0]  = mk(1, 5,  0, 0, 6'h00, 0,  1, 0, 0, 8'h00, 0);
      tbl[1]  = mk(0, 0,  0, 0, 6'h00, 0,  0, 0, 1, 8'hC5, 1);
      tbl[2]  = mk(0, 0,  0, 0, 6'h00, 0,  1, 0, 0, 8'h00, 0);
      tbl[3]  = mk(1, 10, 3, 0, 6'h00, 0,  1, 0, 0, 8'h00, 0);
      tbl[4]  = mk(0, 0,  0, 0, 6'h00, 0,  0, 0, 1, 8'h4A, 1);
      tbl[5]  = mk(0, 0,  0, 1, 6'h01, 0,  0, 1, 1, 8'h01, 1);
      tbl[6]  = mk(0, 0,  0, 1, 6'h02, 0,  0, 1, 1, 8'h02, 1);
      tbl[7]  = mk(0, 0,  0, 1, 6'h03, 0,  0, 1, 1, 8'h83, 1);
      tbl[8]  = mk(0, 0,  0, 0, 6'h00, 0,  1, 0, 0, 8'h00, 0);
      tbl[9]  = mk(1, 3,  1, 0, 6'h00, 0,  1, 0, 0, 8'h00, 0);
      tbl[10] = mk(0, 0,  0, 0, 6'h00, 1,  0, 0, 0, 8'h43, 1);
      tbl[11] = mk(0, 0,  0, 0, 6'h00, 1,  0, 0, 0, 8'h43, 1);
      tbl[12] = mk(0, 0,  0, 0, 6'h00, 1,  0, 0, 0, 8'h43, 1);
      tbl[13] = mk(0, 0,  0, 0, 6'h00, 1,  0, 0, 0, 8'h43, 1);
      tbl[14] = mk(0, 0,  0, 0, 6'h00, 0,  0, 0, 1, 8'h43, 1);
      tbl[15] = mk(0, 0,  0, 1, 6'h15, 0,  0, 1, 1, 8'h95, 1);
      tbl[16] = mk(0, 0,  0, 0, 6'h00, 0,  1, 0, 0, 8'h00, 0);
      tbl[17] = mk(1, 0,  2, 0, 6'h00, 0,  1, 0, 0, 8'h00, 0);
      tbl[18] = mk(0, 0,  0, 0, 6'h00, 0,  0, 0, 1, 8'h40, 1);
      tbl[19] = mk(1, 7,  1, 1, 6'h2A, 0,  0, 1, 1, 8'h2A, 1);
      tbl[20] = mk(0, 0,  0, 0, 6'h11, 0,  0, 0, 0, 8'h91, 1);
      tbl[21] = mk(0, 0,  0, 0, 6'h11, 0,  0, 0, 0, 8'h91, 1);
      tbl[22] = mk(0, 0,  0, 1, 6'h3F, 1,  0, 0, 0, 8'hBF, 1);
      tbl[23] = mk(0, 0,  0, 1, 6'h3F, 0,  0, 1, 1, 8'hBF, 1);
      tbl[24] = mk(0, 0,  0, 0, 6'h00, 0,  1, 0, 0, 8'h00, 0);

      rst = 1; pkt_valid = 0; pkt_dest = 0; pkt_len = 0;
      data_valid = 0; data = 0; router_out_full = 0;
      repeat (2) @(posedge clk);

      for (int i = 0; i < 25; i++) begin
         cyc_in(0, tbl[i].pv, tbl[i].d, tbl[i].l, tbl[i].dv, tbl[i].dat, tbl[i].f);
         chk($sformatf("tbl%0d_pkt_ready", i), pkt_ready, tbl[i].e_pr);
         chk($sformatf("tbl%0d_data_ready", i), data_ready, tbl[i].e_dr);
         chk($sformatf("tbl%0d_wr_en", i), local_wr_en, tbl[i].e_wr);
         chk($sformatf("tbl%0d_flit", i), local_in_flit, tbl[i].e_flit);
         chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
      end
`ifdef NOC_INJECTOR_STATS_EN
      chk("stat_pkts_tbl", stat_pkts, 4);
      chk("stat_flits_tbl", stat_flits, 10);
      chk("stat_stalls_tbl", stat_stalls, 5);
`endif

      // Reset in the middle of a len=5 packet after two bodies.
      cyc_in(0, 1, 2, 5, 0, 6'h00, 0);
      cyc_in(0, 0, 0, 0, 0, 6'h00, 0);
      chk("rstmid_head", local_in_flit, 8'h42);
      cyc_in(0, 0, 0, 0, 1, 6'h0A, 0);
      chk("rstmid_body1", local_in_flit, 8'h0A);
      cyc_in(0, 0, 0, 0, 1, 6'h0B, 0);
      chk("rstmid_body2_wr", local_wr_en, 1);
      cyc_in(1, 0, 0, 0, 0, 6'h0C, 0);
      cyc_in(0, 0, 0, 0, 1, 6'h0D, 0);
      chk("rstmid_wr_en", local_wr_en, 0);
      chk("rstmid_data_ready", data_ready, 0);
      chk("rstmid_pkt_ready", pkt_ready, 1);
      chk("rstmid_busy", busy, 0);
      chk("rstmid_flit", local_in_flit, 0);
`ifdef NOC_INJECTOR_STATS_EN
      chk("rstmid_stat_clr", stat_flits, 0);
`endif
      cyc_in(0, 1, 9, 0, 0, 6'h00, 0);
      cyc_in(0, 0, 0, 0, 0, 6'h00, 0);
      chk("after_rst_single_wr", local_wr_en, 1);
      chk("after_rst_single_flit", local_in_flit, 8'hC9);
      cyc_in(0, 0, 0, 0, 0, 6'h00, 0);
      chk("after_rst_idle", pkt_ready, 1);

      // Maximum length packet.
`ifdef NOC_INJECTOR_STATS_EN
      pk0 = stat_pkts;
`endif
      cyc_in(0, 1, 15, 15, 0, 6'h00, 0);
      nfl = 0; ntail = 0; first_flit = 0; last_flit = 0;
      for (int i = 0; i < 40; i++) begin
         cyc_in(0, 0, 0, 0, 1, 6'($urandom), 0);
         if (!busy) break;
         if (local_wr_en) begin
            if (nfl == 0) first_flit = local_in_flit;
            last_flit = local_in_flit;
            if (local_in_flit[7:6] == 2'b10) ntail++;
            nfl++;
         end
      end
      chk("maxlen_flits", nfl, 16);
      chk("maxlen_tails", ntail, 1);
      chk("maxlen_head", first_flit, 8'h4F);
      chk("maxlen_last_type", last_flit[7:6], 2'b10);
`ifdef NOC_INJECTOR_STATS_EN
      chk("maxlen_stat_pkts", stat_pkts, pk0 + 16'd1);
`endif

      // Random traffic against the flit-queue model (starts in IDLE).
      q.delete();
      for (int i = 0; i < 3000; i++) begin
         cyc_in(($urandom_range(199) == 0), ($urandom_range(1) == 1), 4'($urandom),
                4'($urandom), ($urandom_range(3) != 0), 6'($urandom),
                ($urandom_range(3) == 0));
         model_cycle();
      end
      for (int i = 0; i < 40 && q.size() != 0; i++) begin
         cyc_in(0, 0, 0, 0, 1, 6'($urandom), 0);
         model_cycle();
      end
      chk("drain_empty", q.size(), 0);
      cyc_in(0, 0, 0, 0, 0, 6'h00, 0);
      chk("drain_pkt_ready", pkt_ready, 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
